// File: rtl/spi_regfile_pkg.sv
// Shared types and defaults for the SPI configuration register slave.
package spi_regfile_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 256;

  localparam logic WRITE = 1'b1;
  localparam logic READ  = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_RDATA = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_regfile_slave_burst_if.sv
// SPI pad signals plus the core-side configuration and write-strobe bus.
interface spi_regfile_slave_burst_if
  import spi_regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              MOSI;
  logic              CSN;
  logic              MISO;
  logic              MISO_enable;
  logic [ADDR_W-1:0] cfg_rd_addr;
  logic [DATA_W-1:0] cfg_rd_data;
  logic              wr_strobe;
  logic [ADDR_W-1:0] wr_addr;

  modport slave (
    input  MOSI,
    input  CSN,
    input  cfg_rd_addr,
    output MISO,
    output MISO_enable,
    output cfg_rd_data,
    output wr_strobe,
    output wr_addr
  );

  modport master (
    output MOSI,
    output CSN,
    output cfg_rd_addr,
    input  MISO,
    input  MISO_enable,
    input  cfg_rd_data,
    input  wr_strobe,
    input  wr_addr
  );

endinterface

// File: rtl/spi_regfile_slave_burst_regfile_2r1w.sv
// DEPTH x DATA_W register file, one write port and two combinational reads.
module regfile_2r1w
  import spi_regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_data,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic hit(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && hit(waddr)) begin
      mem[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  // Unimplemented addresses read as zero
  always_comb begin
    a_data = '0;
    b_data = '0;
    if (hit(a_addr)) a_data = mem[a_addr[IDX_W-1:0]];
    if (hit(b_addr)) b_data = mem[b_addr[IDX_W-1:0]];
  end

endmodule

// File: rtl/spi_regfile_slave_burst.sv
// SPI mode-0 slave with burst register file access for the modulator config.
module spi_regfile_slave_burst
  import spi_regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int BURST_EN = 1
) (
  input  logic SCLK,
  input  logic rst_n,
  spi_regfile_slave_burst_if.slave bus
);

  localparam int SH_W  = max_int(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(SH_W + 1);

  state_t            state_q, state_d;
  logic [SH_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              strobe_q, strobe_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic              miso_q, miso_en_q;

  logic              we;
  logic [ADDR_W-1:0] addr_full;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rd_spi;
  logic              last_addr;
  logic              last_data;

  assign addr_full = {shift_q[ADDR_W-2:0], bus.MOSI};
  assign wdata     = {shift_q[DATA_W-2:0], bus.MOSI};
  assign addr_inc  = addr_q + ADDR_W'(1);
  assign last_addr = (cnt_q == CNT_W'(ADDR_W - 1));
  assign last_data = (cnt_q == CNT_W'(DATA_W - 1));

  regfile_2r1w #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rf (
    .clk    (SCLK),
    .rst_n  (rst_n),
    .we     (we),
    .waddr  (addr_q),
    .wdata  (wdata),
    .a_addr (sel_addr),
    .a_data (rd_spi),
    .b_addr (bus.cfg_rd_addr),
    .b_data (bus.cfg_rd_data)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = {shift_q[SH_W-2:0], bus.MOSI};
    cnt_d    = cnt_q + CNT_W'(1);
    addr_d   = addr_q;
    rw_d     = rw_q;
    tx_d     = tx_q;
    strobe_d = 1'b0;
    wa_d     = wa_q;
    we       = 1'b0;
    sel_addr = addr_inc;
    if (bus.CSN) begin
      // Deselect aborts any partial word
      state_d = S_IDLE;
      shift_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          rw_d    = bus.MOSI;
          shift_d = '0;
          cnt_d   = '0;
          state_d = S_ADDR;
        end
        S_ADDR: begin
          if (last_addr) begin
            addr_d   = addr_full;
            cnt_d    = '0;
            sel_addr = addr_full;
            if (rw_q == WRITE) begin
              state_d = S_WDATA;
            end else begin
              state_d = S_RDATA;
              tx_d    = rd_spi;
            end
          end
        end
        S_WDATA: begin
          if (last_data) begin
            we       = 1'b1;
            strobe_d = 1'b1;
            wa_d     = addr_q;
            cnt_d    = '0;
            if (BURST_EN != 0) addr_d = addr_inc;
            else state_d = S_HOLD;
          end
        end
        S_RDATA: begin
          tx_d = tx_q << 1;
          if (last_data) begin
            cnt_d = '0;
            if (BURST_EN != 0) begin
              addr_d = addr_inc;
              tx_d   = rd_spi;
            end else begin
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          shift_d = shift_q;
          cnt_d   = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge SCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      rw_q     <= READ;
      tx_q     <= '0;
      strobe_q <= 1'b0;
      wa_q     <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      tx_q     <= tx_d;
      strobe_q <= strobe_d;
      wa_q     <= wa_d;
    end
  end

  // MISO launches half a cycle ahead of the master's sampling edge
  always_ff @(negedge SCLK or negedge rst_n) begin
    if (!rst_n) begin
      miso_q    <= 1'b0;
      miso_en_q <= 1'b0;
    end else if (state_q == S_RDATA) begin
      miso_q    <= tx_q[DATA_W-1];
      miso_en_q <= 1'b1;
    end else begin
      miso_q    <= 1'b0;
      miso_en_q <= 1'b0;
    end
  end

  assign bus.MISO        = miso_q;
  assign bus.MISO_enable = miso_en_q & ~bus.CSN;
  assign bus.wr_strobe   = strobe_q;
  assign bus.wr_addr     = wa_q;

endmodule

// File: tb/tb_spi_regfile_slave_burst.sv
// Directed bench: default, DEPTH=200 and BURST_EN=0 slaves on one SPI bus.
module tb_spi_regfile_slave_burst;
  import spi_regfile_pkg::*;

  logic       sclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mosi = 1'b0;
  logic       csn = 1'b1;
  logic [7:0] cfg_addr = 8'h00;

  int checks = 0;
  int errors = 0;
  int st0 = 0, st1 = 0, st2 = 0;
  logic [7:0] wa0 = 8'h00, wa1 = 8'h00;
  logic s0, s1, e0, en_all;
  logic [7:0] rx0, rx1;
  int base0, base1, base2;

  always #5 sclk = ~sclk;

  spi_regfile_slave_burst_if #(.ADDR_W(8), .DATA_W(8)) b0 ();
  spi_regfile_slave_burst_if #(.ADDR_W(8), .DATA_W(8)) b1 ();
  spi_regfile_slave_burst_if #(.ADDR_W(8), .DATA_W(8)) b2 ();

  assign b0.MOSI = mosi;
  assign b0.CSN = csn;
  assign b0.cfg_rd_addr = cfg_addr;
  assign b1.MOSI = mosi;
  assign b1.CSN = csn;
  assign b1.cfg_rd_addr = cfg_addr;
  assign b2.MOSI = mosi;
  assign b2.CSN = csn;
  assign b2.cfg_rd_addr = cfg_addr;

  spi_regfile_slave_burst #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(256), .BURST_EN(1)
  ) u0 (.SCLK(sclk), .rst_n(rst_n), .bus(b0.slave));

  spi_regfile_slave_burst #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(200), .BURST_EN(1)
  ) u1 (.SCLK(sclk), .rst_n(rst_n), .bus(b1.slave));

  spi_regfile_slave_burst #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(256), .BURST_EN(0)
  ) u2 (.SCLK(sclk), .rst_n(rst_n), .bus(b2.slave));

  // Strobe is high for whole cycles, so each high cycle is seen once here
  always @(negedge sclk) begin
    if (b0.wr_strobe) begin
      st0 = st0 + 1;
      wa0 = b0.wr_addr;
    end
    if (b1.wr_strobe) begin
      st1 = st1 + 1;
      wa1 = b1.wr_addr;
    end
    if (b2.wr_strobe) st2 = st2 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge sclk);
    #1;
    csn = 1'b0;
    mosi = b;
    s0 = b0.MISO;
    s1 = b1.MISO;
    e0 = b0.MISO_enable;
  endtask

  task automatic start(input logic rw, input logic [7:0] a);
    send_bit(rw);
    for (int i = 7; i >= 0; i--) send_bit(a[i]);
  endtask

  task automatic wbyte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic rbyte();
    en_all = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b0);
      rx0[i] = s0;
      rx1[i] = s1;
      en_all = en_all & e0;
    end
  endtask

  task automatic end_frame();
    @(negedge sclk);
    #1;
    csn = 1'b1;
    mosi = 1'b0;
    repeat (2) @(negedge sclk);
    #1;
  endtask

  task automatic cfg_chk(input string tag, input int d,
                         input logic [7:0] a, input logic [7:0] exp);
    cfg_addr = a;
    #1;
    case (d)
      0: chk(tag, b0.cfg_rd_data, exp);
      1: chk(tag, b1.cfg_rd_data, exp);
      default: chk(tag, b2.cfg_rd_data, exp);
    endcase
  endtask

  initial begin
    repeat (3) @(negedge sclk);
    #1;
    chk("rst_miso", b0.MISO, 1'b0);
    chk("rst_en", b0.MISO_enable, 1'b0);
    chk("rst_strobe", b0.wr_strobe, 1'b0);
    chk("rst_wr_addr", b0.wr_addr, 8'h00);
    rst_n = 1'b1;
    cfg_chk("rst_reg12", 0, 8'h12, 8'h00);

    // Single write then readback
    base0 = st0;
    start(WRITE, 8'h12);
    wbyte(8'hA5);
    end_frame();
    chk("t1_strobes", st0 - base0, 1);
    chk("t1_wr_addr", wa0, 8'h12);
    cfg_chk("t1_cfg12", 0, 8'h12, 8'hA5);
    start(READ, 8'h12);
    rbyte();
    chk("t1_read", rx0, 8'hA5);
    chk("t1_read_en", en_all, 1'b1);
    end_frame();
    chk("t1_idle_en", b0.MISO_enable, 1'b0);

    // Burst write across the address wrap, then burst read
    base0 = st0;
    start(WRITE, 8'hFE);
    wbyte(8'h11);
    wbyte(8'h22);
    wbyte(8'h33);
    end_frame();
    chk("t2_strobes", st0 - base0, 3);
    chk("t2_last_addr", wa0, 8'h00);
    cfg_chk("t2_cfgFE", 0, 8'hFE, 8'h11);
    cfg_chk("t2_cfgFF", 0, 8'hFF, 8'h22);
    cfg_chk("t2_cfg00", 0, 8'h00, 8'h33);
    start(READ, 8'hFE);
    rbyte();
    chk("t2_rdFE", rx0, 8'h11);
    rbyte();
    chk("t2_rdFF", rx0, 8'h22);
    rbyte();
    chk("t2_rd00", rx0, 8'h33);
    end_frame();

    // Aborted write must not commit or strobe
    start(WRITE, 8'h40);
    wbyte(8'h3C);
    end_frame();
    base0 = st0;
    start(WRITE, 8'h40);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    end_frame();
    chk("t3_abort_strobe", st0 - base0, 0);
    cfg_chk("t3_cfg40", 0, 8'h40, 8'h3C);
    start(WRITE, 8'h41);
    wbyte(8'h5A);
    end_frame();
    chk("t3_next_strobe", st0 - base0, 1);
    chk("t3_next_addr", wa0, 8'h41);
    cfg_chk("t3_cfg41", 0, 8'h41, 8'h5A);

    // Out-of-range address on the DEPTH=200 slave
    base1 = st1;
    start(WRITE, 8'hC8);
    wbyte(8'h77);
    end_frame();
    chk("t5_strobes", st1 - base1, 1);
    chk("t5_wr_addr", wa1, 8'hC8);
    cfg_chk("t5_cfgC8", 1, 8'hC8, 8'h00);
    cfg_chk("t5_cfgC7", 1, 8'hC7, 8'h00);
    start(READ, 8'hC8);
    rbyte();
    chk("t5_read_oor", rx1, 8'h00);
    chk("t5_read_full", rx0, 8'h77);
    end_frame();

    // Single-word frames on the BURST_EN=0 slave
    base2 = st2;
    start(WRITE, 8'h05);
    wbyte(8'h9A);
    wbyte(8'hBC);
    end_frame();
    chk("t6_strobes", st2 - base2, 1);
    cfg_chk("t6_cfg05", 2, 8'h05, 8'h9A);
    cfg_chk("t6_cfg06", 2, 8'h06, 8'h00);
    cfg_chk("t6_burst_cfg06", 0, 8'h06, 8'hBC);

    // Reset in the middle of a read of 0x41 (bit 3 is a one)
    start(READ, 8'h41);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    @(negedge sclk);
    #1;
    chk("t4_pre_miso", b0.MISO, 1'b1);
    chk("t4_pre_en", b0.MISO_enable, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t4_miso", b0.MISO, 1'b0);
    chk("t4_en", b0.MISO_enable, 1'b0);
    cfg_chk("t4_cfg12", 0, 8'h12, 8'h00);
    cfg_chk("t4_cfg40", 0, 8'h40, 8'h00);
    csn = 1'b1;
    @(negedge sclk);
    #1;
    rst_n = 1'b1;
    start(READ, 8'h12);
    rbyte();
    chk("t4_read12", rx0, 8'h00);
    chk("t4_read_en", en_all, 1'b1);
    end_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
